// File: rtl/fcims_restock_ctrl.sv
// FCIMS restock controller: per-item stock table plus purchase budget.
// Each request is costed with a shift-add multiplier, then committed or rejected.
module fcims_restock_ctrl #(
    parameter int NITEMS   = 4,
    parameter int CT_W     = 4,
    parameter int PRICE_W  = 4,
    parameter int BUDGET_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bud_load,
    input  logic [BUDGET_W-1:0]       bud_init,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [$clog2(NITEMS)-1:0] req_item,
    input  logic [CT_W-1:0]           req_qty,
    input  logic [PRICE_W-1:0]        req_ucost,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [1:0]                resp_code,
    output logic [BUDGET_W-1:0]       resp_cost,
    output logic [CT_W-1:0]           resp_new_ct,
    output logic [BUDGET_W-1:0]       budget,
    input  logic [$clog2(NITEMS)-1:0] rd_item,
    output logic [CT_W-1:0]           rd_ct
);

    localparam int IDX_W = $clog2(NITEMS);
    localparam int CNT_W = $clog2(CT_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_CHECK = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               item_q, item_d;
    logic [CT_W-1:0]                qty_q, qty_d;
    logic [CT_W-1:0]                mplier_q, mplier_d;
    logic [BUDGET_W-1:0]            mcand_q, mcand_d;
    logic [BUDGET_W-1:0]            acc_q, acc_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [BUDGET_W-1:0]            budget_q, budget_d;
    logic [NITEMS-1:0][CT_W-1:0]    stock_q, stock_d;
    logic                           resp_valid_q, resp_valid_d;
    logic [1:0]                     resp_code_q, resp_code_d;
    logic [BUDGET_W-1:0]            resp_cost_q, resp_cost_d;
    logic [CT_W-1:0]                resp_new_ct_q, resp_new_ct_d;
    logic [CT_W:0]                  sum_s;

    // State register and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            item_q        <= '0;
            qty_q         <= '0;
            mplier_q      <= '0;
            mcand_q       <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            budget_q      <= '0;
            stock_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_code_q   <= 2'b00;
            resp_cost_q   <= '0;
            resp_new_ct_q <= '0;
        end else begin
            state_q       <= state_d;
            item_q        <= item_d;
            qty_q         <= qty_d;
            mplier_q      <= mplier_d;
            mcand_q       <= mcand_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            budget_q      <= budget_d;
            stock_q       <= stock_d;
            resp_valid_q  <= resp_valid_d;
            resp_code_q   <= resp_code_d;
            resp_cost_q   <= resp_cost_d;
            resp_new_ct_q <= resp_new_ct_d;
        end
    end

    // Next-state and datapath update for IDLE -> MUL -> CHECK -> RESP.
    always_comb begin
        state_d       = state_q;
        item_d        = item_q;
        qty_d         = qty_q;
        mplier_d      = mplier_q;
        mcand_d       = mcand_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        budget_d      = budget_q;
        stock_d       = stock_q;
        resp_valid_d  = resp_valid_q;
        resp_code_d   = resp_code_q;
        resp_cost_d   = resp_cost_q;
        resp_new_ct_d = resp_new_ct_q;
        sum_s         = {1'b0, stock_q[item_q]} + {1'b0, qty_q};

        case (state_q)
            S_IDLE: begin
                if (bud_load) begin
                    budget_d = bud_init;
                end else if (req_valid) begin
                    item_d   = req_item;
                    qty_d    = req_qty;
                    mplier_d = req_qty;
                    mcand_d  = BUDGET_W'(req_ucost);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // LSB-first: the multiplicand doubles as the multiplier shifts right.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[BUDGET_W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[CT_W-1:1]};
                if (cnt_q == LAST_BIT) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CHECK: begin
                resp_cost_d  = acc_q;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
                if (acc_q > budget_q) begin
                    resp_code_d   = 2'b01;
                    resp_new_ct_d = stock_q[item_q];
                end else if (sum_s[CT_W]) begin
                    resp_code_d   = 2'b10;
                    resp_new_ct_d = stock_q[item_q];
                end else begin
                    resp_code_d      = 2'b00;
                    resp_new_ct_d    = sum_s[CT_W-1:0];
                    stock_d[item_q]  = sum_s[CT_W-1:0];
                    budget_d         = budget_q - acc_q;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready is gated by reset so it reads low while reset is held.
    assign req_ready   = reset && (state_q == S_IDLE) && !bud_load;
    assign resp_valid  = resp_valid_q;
    assign resp_code   = resp_code_q;
    assign resp_cost   = resp_cost_q;
    assign resp_new_ct = resp_new_ct_q;
    assign budget      = budget_q;
    assign rd_ct       = stock_q[rd_item];

endmodule

// File: tb/tb_fcims_restock_ctrl.sv
// Self-checking bench for fcims_restock_ctrl: directed scenarios plus randomized
// requests compared against an arithmetic model of stock and budget.
module tb_fcims_restock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       bud_load;
    logic [7:0] bud_init;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_item;
    logic [3:0] req_qty;
    logic [3:0] req_ucost;
    logic       resp_valid;
    logic       resp_ready;
    logic [1:0] resp_code;
    logic [7:0] resp_cost;
    logic [3:0] resp_new_ct;
    logic [7:0] budget;
    logic [1:0] rd_item;
    logic [3:0] rd_ct;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] m_stock [4];
    logic [7:0] m_budget;

    fcims_restock_ctrl dut (
        .clk(clk), .reset(reset), .bud_load(bud_load), .bud_init(bud_init),
        .req_valid(req_valid), .req_ready(req_ready), .req_item(req_item),
        .req_qty(req_qty), .req_ucost(req_ucost), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_code(resp_code), .resp_cost(resp_cost),
        .resp_new_ct(resp_new_ct), .budget(budget), .rd_item(rd_item), .rd_ct(rd_ct)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stock[i] = 4'd0;
        m_budget = 8'd0;
    endtask

    // Reference: cost is a plain product; budget checked before capacity.
    task automatic model_req(input logic [1:0] item, input logic [3:0] qty, input logic [3:0] ucost,
                             output logic [1:0] code, output logic [7:0] cost, output logic [3:0] nct);
        int c, s;
        c = int'(ucost) * int'(qty);
        s = int'(m_stock[item]) + int'(qty);
        cost = 8'(c);
        if (c > int'(m_budget)) begin
            code = 2'b01; nct = m_stock[item];
        end else if (s > 15) begin
            code = 2'b10; nct = m_stock[item];
        end else begin
            code = 2'b00; nct = 4'(s);
            m_stock[item] = 4'(s);
            m_budget = 8'(int'(m_budget) - c);
        end
    endtask

    task automatic load_budget(input logic [7:0] v);
        @(negedge clk); bud_load = 1'b1; bud_init = v;
        @(negedge clk); bud_load = 1'b0;
        m_budget = v;
    endtask

    // Drives one request; lat counts edges from the accept edge (=1) to resp_valid.
    task automatic do_req(input logic [1:0] item, input logic [3:0] qty, input logic [3:0] ucost,
                          input bit consume, output int lat, output bit to);
        int w;
        to = 1'b0; lat = 0;
        @(negedge clk);
        req_item = item; req_qty = qty; req_ucost = ucost; req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin @(negedge clk); w++; end
        if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
        @(posedge clk); #1 req_valid = 1'b0; lat = 1;
        while (!resp_valid && lat < 30) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) begin to = 1'b1; return; end
        if (consume) begin
            resp_ready = 1'b1; @(posedge clk); #1 resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; bud_load = 1'b0; bud_init = 8'h00; req_valid = 1'b0;
        req_item = 2'd0; req_qty = 4'd0; req_ucost = 4'd0; resp_ready = 1'b0; rd_item = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b exp 0", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid); else n_pass++;
        n_checks++; if (resp_code !== 2'b00 || resp_cost !== 8'h00 || resp_new_ct !== 4'h0)
            $display("FAIL rst_resp_fields got %h/%h/%h exp 0/0/0", resp_code, resp_cost, resp_new_ct); else n_pass++;
        n_checks++; if (budget !== 8'h00) $display("FAIL rst_budget got %h exp 00", budget); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            rd_item = 2'(i); #1;
            n_checks++; if (rd_ct !== 4'h0) $display("FAIL rst_stock%0d got %h exp 0", i, rd_ct); else n_pass++;
        end
        @(negedge clk); reset = 1'b1; #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_directed();
        logic [1:0] it [5] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
        logic [3:0] qt [5] = '{4'd5, 4'd12, 4'd3, 4'd15, 4'd1};
        logic [3:0] uc [5] = '{4'd4, 4'd1, 4'd5, 4'd15, 4'd15};
        bit         ld [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] lv [5] = '{8'h20, 8'h00, 8'h00, 8'hFF, 8'h00};
        bit         hd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] ec; logic [7:0] ecost; logic [3:0] enct;
        int lat; bit to;
        for (int r = 0; r < 5; r++) begin
            if (ld[r]) load_budget(lv[r]);
            model_req(it[r], qt[r], uc[r], ec, ecost, enct);
            do_req(it[r], qt[r], uc[r], !hd[r], lat, to);
            n_checks++; if (to || lat != 6) $display("FAIL dir%0d_latency got %0d (timeout %b) exp 6", r, lat, to); else n_pass++;
            if (hd[r]) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (resp_valid !== 1'b1 || resp_code !== ec || resp_cost !== ecost || resp_new_ct !== enct || req_ready !== 1'b0)
                        $display("FAIL dir%0d_hold%0d got v%b c%h $%h n%h rdy%b exp v1 c%h $%h n%h rdy0",
                                 r, k, resp_valid, resp_code, resp_cost, resp_new_ct, req_ready, ec, ecost, enct);
                    else n_pass++;
                end
                resp_ready = 1'b1; @(posedge clk); #1 resp_ready = 1'b0;
            end
            n_checks++; if (resp_valid !== 1'b0) $display("FAIL dir%0d_drop got %b exp 0", r, resp_valid); else n_pass++;
            n_checks++; if (resp_code !== ec) $display("FAIL dir%0d_code got %b exp %b", r, resp_code, ec); else n_pass++;
            n_checks++; if (resp_cost !== ecost) $display("FAIL dir%0d_cost got %h exp %h", r, resp_cost, ecost); else n_pass++;
            n_checks++; if (resp_new_ct !== enct) $display("FAIL dir%0d_newct got %h exp %h", r, resp_new_ct, enct); else n_pass++;
            n_checks++; if (budget !== m_budget) $display("FAIL dir%0d_budget got %h exp %h", r, budget, m_budget); else n_pass++;
            rd_item = it[r]; #1;
            n_checks++; if (rd_ct !== m_stock[it[r]]) $display("FAIL dir%0d_rdct got %h exp %h", r, rd_ct, m_stock[it[r]]); else n_pass++;
        end
    endtask

    task automatic test_load_collision();
        logic [1:0] ec; logic [7:0] ecost; logic [3:0] enct;
        int lat; bit to;
        @(negedge clk);
        bud_load = 1'b1; bud_init = 8'h40;
        req_valid = 1'b1; req_item = 2'd3; req_qty = 4'd0; req_ucost = 4'd7; #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL coll_ready got %b exp 0", req_ready); else n_pass++;
        @(posedge clk); #1;
        bud_load = 1'b0; m_budget = 8'h40; #1;
        n_checks++; if (budget !== 8'h40) $display("FAIL coll_budget got %h exp 40", budget); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL coll_still_idle got %b exp 1", req_ready); else n_pass++;
        req_valid = 1'b0;
        model_req(2'd3, 4'd0, 4'd7, ec, ecost, enct);
        do_req(2'd3, 4'd0, 4'd7, 1'b1, lat, to);
        n_checks++; if (to || resp_code !== ec || resp_cost !== ecost || resp_new_ct !== enct)
            $display("FAIL qty0_resp got c%b $%h n%h to%b exp c%b $%h n%h", resp_code, resp_cost, resp_new_ct, to, ec, ecost, enct);
        else n_pass++;
        n_checks++; if (budget !== m_budget) $display("FAIL qty0_budget got %h exp %h", budget, m_budget); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] ec; logic [7:0] ecost; logic [3:0] enct;
        int lat; bit to;
        @(negedge clk);
        req_valid = 1'b1; req_item = 2'd1; req_qty = 4'd7; req_ucost = 4'd3;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk); reset = 1'b0; #1;
        n_checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL midrst_hs got rdy%b v%b exp rdy0 v0", req_ready, resp_valid); else n_pass++;
        n_checks++; if (budget !== 8'h00) $display("FAIL midrst_budget got %h exp 00", budget); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            rd_item = 2'(i); #1;
            n_checks++; if (rd_ct !== 4'h0) $display("FAIL midrst_stock%0d got %h exp 0", i, rd_ct); else n_pass++;
        end
        @(negedge clk); reset = 1'b1;
        model_reset();
        load_budget(8'h30);
        model_req(2'd1, 4'd7, 4'd3, ec, ecost, enct);
        do_req(2'd1, 4'd7, 4'd3, 1'b1, lat, to);
        n_checks++; if (to || lat != 6 || resp_code !== ec || resp_cost !== ecost || resp_new_ct !== enct)
            $display("FAIL midrst_after got c%b $%h n%h lat%0d exp c%b $%h n%h lat6", resp_code, resp_cost, resp_new_ct, lat, ec, ecost, enct);
        else n_pass++;
        n_checks++; if (budget !== m_budget) $display("FAIL midrst_after_budget got %h exp %h", budget, m_budget); else n_pass++;
    endtask

    task automatic test_random();
        logic [1:0] ec, it; logic [7:0] ecost; logic [3:0] enct, q, u;
        int lat; bit to;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) load_budget(8'($urandom_range(0, 255)));
            it = 2'($urandom_range(0, 3)); q = 4'($urandom_range(0, 15)); u = 4'($urandom_range(0, 15));
            model_req(it, q, u, ec, ecost, enct);
            do_req(it, q, u, 1'b1, lat, to);
            n_checks++;
            if (to || lat != 6 || resp_code !== ec || resp_cost !== ecost || resp_new_ct !== enct || budget !== m_budget)
                $display("FAIL rnd%0d i%0d q%0d u%0d got c%b $%h n%h b%h lat%0d exp c%b $%h n%h b%h lat6",
                         n, it, q, u, resp_code, resp_cost, resp_new_ct, budget, lat, ec, ecost, enct, m_budget);
            else n_pass++;
            rd_item = 2'($urandom_range(0, 3)); #1;
            n_checks++; if (rd_ct !== m_stock[rd_item]) $display("FAIL rnd%0d_rdct item%0d got %h exp %h", n, rd_item, rd_ct, m_stock[rd_item]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_load_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
